// File: rtl/if_prefetch_queue.sv
// ---------------------------------------------------------------------------
// if_prefetch_queue
//
// Instruction-fetch front end. Owns the fetch PC, issues word requests to a
// variable-latency, in-order instruction memory and buffers the returned
// words together with their PC+4 in a small FIFO that feeds the IF/ID
// register. A taken-branch redirect flushes the FIFO, reloads the PC and
// marks every request still in flight as "to be discarded".
//
// Handshakes:
//   imem request : a request transfers on a rising edge where both
//                  imem_req_valid and imem_req_ready are 1. Once valid is
//                  raised, imem_req_addr stays unchanged until that transfer,
//                  unless a redirect retargets the fetch (valid drops then).
//   imem response: one imem_resp_valid pulse per accepted request, in order.
//   IF/ID        : the head entry is consumed on a rising edge where id_valid
//                  is 1 and stall is 0.
//
// Parameters:
//   DEPTH           FIFO entries {instr, pc_plus4}; power of two, >= 2
//   MAX_OUTSTANDING accepted requests that may await a response
//   RESET_PC        fetch PC after reset
//
// Ports:
//   clk, reset           clock (rising edge), synchronous active-low reset
//   redirect/redirect_pc taken branch from ID and its target (bits[1:0] forced 0)
//   stall                hazard-unit stall, holds the FIFO head
//   imem_req_*           request channel toward instruction memory
//   imem_resp_*          response channel from instruction memory
//   id_valid/id_instr/id_pc_plus4  FIFO head toward IF/ID
//   perf_fetch_cnt/perf_flush_cnt  only when IFQ_PERF_CNT_EN is defined:
//                        responses pushed and redirects taken (wrapping)
//   dbg_state            FSM state (0 = RUN, 1 = DRAIN)
//
// Optional build macro: IFQ_PERF_CNT_EN adds the two performance counters.
// ---------------------------------------------------------------------------
module if_prefetch_queue #(
    parameter int          DEPTH           = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc_plus4,
`ifdef IFQ_PERF_CNT_EN
    output logic [31:0] perf_fetch_cnt,
    output logic [15:0] perf_flush_cnt,
`endif
    output logic        dbg_state
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int AW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [OW-1:0] MAX_O   = OW'(MAX_OUTSTANDING);
    localparam logic [AW-1:0] A_LAST  = AW'(MAX_OUTSTANDING - 1);
    localparam logic [31:0]   DEPTH_W = 32'(DEPTH);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   fifo_instr_q [DEPTH];
    logic [31:0]   fifo_instr_d [DEPTH];
    logic [31:0]   fifo_pc4_q   [DEPTH];
    logic [31:0]   fifo_pc4_d   [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [OW-1:0] outstanding_q, outstanding_d;
    logic [OW-1:0] discard_q, discard_d;
    // Addresses of accepted requests, popped in order as responses return.
    logic [31:0]   ifl_addr_q [MAX_OUTSTANDING];
    logic [31:0]   ifl_addr_d [MAX_OUTSTANDING];
    logic [AW-1:0] ifl_wr_q, ifl_wr_d;
    logic [AW-1:0] ifl_rd_q, ifl_rd_d;

    logic [31:0]   occupancy;
    logic          accept;
    logic          resp_take;
    logic          push;
    logic          pop;

    // Outputs depend on registered state; redirect only masks the valids.
    always_comb begin
        // Credit rule: every accepted request already owns a FIFO slot, so a
        // push can never find the FIFO full.
        occupancy      = 32'(count_q) + 32'(outstanding_q);
        imem_req_valid = !redirect && (outstanding_q < MAX_O) && (occupancy < DEPTH_W);
        imem_req_addr  = fetch_pc_q;
        id_valid       = (count_q != '0) && !redirect;
        id_instr       = (count_q != '0) ? fifo_instr_q[rd_ptr_q] : 32'h0;
        id_pc_plus4    = (count_q != '0) ? fifo_pc4_q[rd_ptr_q]   : 32'h0;
        dbg_state      = state_q;
    end

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        fifo_instr_d  = fifo_instr_q;
        fifo_pc4_d    = fifo_pc4_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        ifl_addr_d    = ifl_addr_q;
        ifl_wr_d      = ifl_wr_q;
        ifl_rd_d      = ifl_rd_q;

        accept    = imem_req_valid && imem_req_ready;
        // A response with nothing outstanding is stale (e.g. issued before a
        // reset) and is ignored entirely.
        resp_take = imem_resp_valid && (outstanding_q != '0);
        push      = resp_take && (discard_q == '0) && !redirect;
        pop       = id_valid && !stall;

        if (accept) begin
            ifl_addr_d[ifl_wr_q] = fetch_pc_q;
            ifl_wr_d             = (ifl_wr_q == A_LAST) ? '0 : ifl_wr_q + 1'b1;
            fetch_pc_d           = fetch_pc_q + 32'd4;
        end

        if (resp_take) begin
            ifl_rd_d = (ifl_rd_q == A_LAST) ? '0 : ifl_rd_q + 1'b1;
            if (discard_q != '0) begin
                discard_d = discard_q - 1'b1;
            end
        end

        case ({accept, resp_take})
            2'b10:   outstanding_d = outstanding_q + 1'b1;
            2'b01:   outstanding_d = outstanding_q - 1'b1;
            default: outstanding_d = outstanding_q;
        endcase

        if (push) begin
            fifo_instr_d[wr_ptr_q] = imem_resp_data;
            fifo_pc4_d[wr_ptr_q]   = ifl_addr_q[ifl_rd_q] + 32'd4;
            wr_ptr_d               = wr_ptr_q + 1'b1;
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // Redirect wins over everything. No request is accepted this cycle
        // (valid is masked), so outstanding_d already reflects any response
        // arriving now; every request still in flight afterwards is stale.
        if (redirect) begin
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            fetch_pc_d = redirect_pc & ~32'h3;
            discard_d  = outstanding_d;
        end

        case (state_q)
            ST_RUN:   if (discard_d != '0) state_d = ST_DRAIN;
            ST_DRAIN: if (discard_d == '0) state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= ST_RUN;
            fetch_pc_q    <= RESET_PC;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
            ifl_wr_q      <= '0;
            ifl_rd_q      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_instr_q[i] <= '0;
                fifo_pc4_q[i]   <= '0;
            end
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                ifl_addr_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            ifl_wr_q      <= ifl_wr_d;
            ifl_rd_q      <= ifl_rd_d;
            fifo_instr_q  <= fifo_instr_d;
            fifo_pc4_q    <= fifo_pc4_d;
            ifl_addr_q    <= ifl_addr_d;
        end
    end

`ifdef IFQ_PERF_CNT_EN
    logic [31:0] perf_fetch_q, perf_fetch_d;
    logic [15:0] perf_flush_q, perf_flush_d;

    always_comb begin
        perf_fetch_d = perf_fetch_q + 32'(push);
        perf_flush_d = perf_flush_q + 16'(redirect);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_fetch_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_fetch_q <= perf_fetch_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_flush_cnt = perf_flush_q;
`endif

endmodule
